// File: rtl/ascii_to_int32.sv
// ---------------------------------------------------------------------------
// ascii_to_int32
//
// Streaming parser: turns a stream of ASCII characters into signed 32-bit
// integers. Numbers are optionally signed runs of decimal digits, separated by
// delimiters (space, tab, LF, CR, comma). Each number finishing on a delimiter
// is presented on int32_out with a valid/ready handshake. Malformed tokens
// raise a one-cycle error pulse with a cause code. After an error, the rest of
// the token is discarded up to the next delimiter.
//
// Parameters
//   ACCEPT_PLUS  1: a leading '+' is a sign; 0: '+' is an invalid character
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   char_in      ASCII character
//   char_valid   char_in is valid
//   char_ready   parser accepts char_in this cycle (low in OUTPUT and reset)
//   int32_out    parsed two's-complement result
//   int32_valid  int32_out is valid (high while in OUTPUT)
//   int32_ready  consumer accepts int32_out
//   error        one-cycle parse-error pulse
//   error_code   cause of the last error: 01 invalid, 10 overflow,
//                11 sign without digits
//   busy         high whenever the parser is not IDLE
// ---------------------------------------------------------------------------
module ascii_to_int32 #(
    parameter bit ACCEPT_PLUS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [31:0] int32_out,
    output logic        int32_valid,
    input  logic        int32_ready,
    output logic        error,
    output logic [1:0]  error_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIGN   = 3'd1,
        ST_DIGITS = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_INVALID  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_NODIGITS = 2'b11;

    // Largest magnitudes representable for each sign.
    localparam logic [35:0] POS_LIMIT = 36'd2147483647;
    localparam logic [35:0] NEG_LIMIT = 36'd2147483648;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;          // magnitude accumulated so far
    logic        neg_q, neg_d;          // token carries a '-' sign
    logic [31:0] out_q, out_d;          // registered result
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic       is_digit;
    logic       is_delim;
    logic       is_minus;
    logic       is_plus;
    logic [3:0] digit_val;

    always_comb begin
        is_digit  = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_delim  = (char_in == 8'h20) || (char_in == 8'h09) ||
                    (char_in == 8'h0A) || (char_in == 8'h0D) ||
                    (char_in == 8'h2C);
        is_minus  = (char_in == 8'h2D);
        // With ACCEPT_PLUS cleared '+' simply falls through to "invalid".
        is_plus   = ACCEPT_PLUS && (char_in == 8'h2B);
        digit_val = char_in[3:0];
    end

    // ------------------------------------------------------------------
    // Accumulator arithmetic: acc*10 + digit without a multiplier.
    // 36 bits hold 10 * (2^32 - 1) + 9, so the compare sees the true value.
    // ------------------------------------------------------------------
    logic [35:0] acc_wide;
    logic [35:0] acc_x10;
    logic [35:0] acc_next;
    logic [35:0] acc_limit;
    logic        acc_overflow;

    always_comb begin
        acc_wide     = {4'd0, acc_q};
        acc_x10      = (acc_wide << 3) + (acc_wide << 1);
        acc_next     = acc_x10 + {32'd0, digit_val};
        acc_limit    = neg_q ? NEG_LIMIT : POS_LIMIT;
        acc_overflow = (acc_next > acc_limit);
    end

    // ------------------------------------------------------------------
    // Handshake signals
    // ------------------------------------------------------------------
    logic accept;

    // Input is refused during reset and while a result waits for the consumer.
    assign char_ready  = rst_n && (state_q != ST_OUTPUT);
    assign accept      = char_valid && char_ready;
    assign int32_valid = (state_q == ST_OUTPUT);
    assign int32_out   = out_q;
    assign error       = error_q;
    assign error_code  = code_q;
    assign busy        = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        out_d   = out_q;
        error_d = 1'b0;
        code_d  = code_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_delim) begin
                        state_d = ST_IDLE;
                    end else if (is_minus) begin
                        state_d = ST_SIGN;
                        neg_d   = 1'b1;
                        acc_d   = 32'd0;
                    end else if (is_plus) begin
                        state_d = ST_SIGN;
                        neg_d   = 1'b0;
                        acc_d   = 32'd0;
                    end else if (is_digit) begin
                        state_d = ST_DIGITS;
                        neg_d   = 1'b0;
                        acc_d   = {28'd0, digit_val};
                    end else begin
                        state_d = ST_SKIP;
                        error_d = 1'b1;
                        code_d  = ERR_INVALID;
                    end
                end
            end

            ST_SIGN: begin
                if (accept) begin
                    if (is_digit) begin
                        state_d = ST_DIGITS;
                        acc_d   = {28'd0, digit_val};
                    end else if (is_delim) begin
                        // The delimiter already ends the token, so no SKIP.
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                        code_d  = ERR_NODIGITS;
                    end else begin
                        state_d = ST_SKIP;
                        error_d = 1'b1;
                        code_d  = ERR_INVALID;
                    end
                end
            end

            ST_DIGITS: begin
                if (accept) begin
                    if (is_digit) begin
                        if (acc_overflow) begin
                            // acc keeps its last in-range value.
                            state_d = ST_SKIP;
                            error_d = 1'b1;
                            code_d  = ERR_OVERFLOW;
                        end else begin
                            acc_d = acc_next[31:0];
                        end
                    end else if (is_delim) begin
                        // Negating 2^31 wraps to 0x80000000, which is exact.
                        state_d = ST_OUTPUT;
                        out_d   = neg_q ? (32'd0 - acc_q) : acc_q;
                    end else begin
                        state_d = ST_SKIP;
                        error_d = 1'b1;
                        code_d  = ERR_INVALID;
                    end
                end
            end

            ST_OUTPUT: begin
                if (int32_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = 32'd0;
                    neg_d   = 1'b0;
                end
            end

            ST_SKIP: begin
                if (accept && is_delim) begin
                    state_d = ST_IDLE;
                    acc_d   = 32'd0;
                    neg_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = 32'd0;
                neg_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            neg_q   <= 1'b0;
            out_q   <= 32'd0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            out_q   <= out_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: doc/ascii_to_int32.md
ASCII_TO_INT32 -- requirements
Module: ascii_to_int32

Interface
REQ-001 SHALL have parameter ACCEPT_PLUS, default 1, meaning: when 1, a leading '+' (0x2B) is accepted as a sign; when 0, '+' is an invalid character.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port char_in  input  8  ASCII character.
REQ-005 SHALL have port char_valid  input  1  char_in is valid.
REQ-006 SHALL have port char_ready  output  1  block accepts char_in this cycle.
REQ-007 SHALL have port int32_out  output  32  parsed signed two's-complement result.
REQ-008 SHALL have port int32_valid  output  1  int32_out is valid.
REQ-009 SHALL have port int32_ready  input  1  consumer accepts int32_out.
REQ-010 SHALL have port error  output  1  one-cycle parse-error pulse.
REQ-011 SHALL have port error_code  output  2  cause of the last error: 01 invalid char, 10 overflow, 11 sign without digits.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 A character SHALL be consumed only on a rising edge where char_valid && char_ready.
REQ-014 char_ready SHALL be combinational from state: 1 in IDLE, SIGN, DIGITS and SKIP; 0 in OUTPUT.
REQ-015 The delimiters SHALL be space 0x20, tab 0x09, LF 0x0A, CR 0x0D and comma 0x2C; digits SHALL be 0x30-0x39.
REQ-016 The FSM states SHALL be IDLE, SIGN, DIGITS, OUTPUT and SKIP.
REQ-017 IDLE transitions on a consumed char SHALL be: delimiter -> stay in IDLE; '-' -> SIGN with neg=1; '+' (if ACCEPT_PLUS) -> SIGN with neg=0; digit -> DIGITS with acc=digit and neg=0; any other char -> error code 01, go to SKIP.
REQ-018 SIGN transitions SHALL be: digit -> DIGITS with acc=digit; delimiter -> error code 11, go to IDLE; any other char (including a second sign) -> error code 01, go to SKIP.
REQ-019 DIGITS transitions SHALL be: digit -> acc = acc*10 + digit; delimiter -> OUTPUT; any other char (including a sign) -> error code 01, go to SKIP.
REQ-020 acc*10 SHALL be computed as (acc<<3)+(acc<<1) in at least 36 bits, with no multiplier inferred.
REQ-021 Overflow SHALL be flagged when the next acc exceeds 2147483647 with neg=0, or exceeds 2147483648 with neg=1; the block SHALL then raise error code 10, go to SKIP, and leave acc unchanged.
REQ-022 Leading zeros SHALL be unlimited and SHALL NOT cause overflow.
REQ-023 SKIP SHALL discard every character until a delimiter is consumed, then go to IDLE, with no further error pulse.
REQ-024 On entry to OUTPUT, int32_out SHALL be registered as neg ? (0 - acc[31:0]) : acc[31:0]; magnitude 2147483648 with neg=1 SHALL yield 0x80000000.
REQ-025 int32_valid SHALL go high in the first cycle after the terminating delimiter is consumed, giving a latency of 1 cycle.
REQ-026 In OUTPUT, int32_valid and int32_out SHALL hold stable until int32_valid && int32_ready; the next state SHALL then be IDLE, with int32_valid low and char_ready high in the following cycle.
REQ-027 The terminating delimiter SHALL be consumed and SHALL NOT be re-examined in IDLE.
REQ-028 error SHALL be high for exactly the one cycle after the offending char is consumed; error_code SHALL hold its value until the next error.
REQ-029 int32_valid and error SHALL never be high in the same cycle.
REQ-030 int32_out SHALL retain its last value after the handshake until the next result is registered.

Reset
REQ-031 When rst_n is low at a rising edge, the block SHALL set state=IDLE, acc=0, neg=0, int32_out=0, int32_valid=0, error=0, error_code=00 and busy=0.
REQ-032 While rst_n is low, char_ready SHALL be 0.
REQ-033 A reset mid-number or in OUTPUT SHALL discard the partial or pending result with no output and no error.

Verification
REQ-034 Bench SHALL drive "123\n" -> int32_out=0x0000007B with int32_valid high 1 cycle after LF is consumed.
REQ-035 Bench SHALL drive "-2147483648 " -> int32_out=0x80000000; then "+0007," -> int32_out=7.
REQ-036 Bench SHALL drive "2147483648,9 " -> error pulse with code 10 at the final '8', no result for the first token, then int32_out=9.
REQ-037 Bench SHALL drive "12a3 -\n" -> error code 01 at 'a', with no output for "12a3"; then error code 11 at LF.
REQ-038 Bench SHALL hold int32_ready=0 for 5 cycles after "42 " -> int32_valid held, int32_out=42 stable, char_ready=0; releasing int32_ready -> IDLE on the next cycle.
REQ-039 Bench SHALL drive "45", assert rst_n=0 for 1 cycle, then drive "9 " -> the only result is 9, with no error.
